uart_word_serializer: RTL and testbench
=======================================

UART_WORD_SERIALIZER -- requirements
Module: uart_word_serializer

Interface
- REQ-001 The block SHALL have parameter WORD_BYTES, default 2, giving the number of bytes per input word.
- REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the word FIFO depth; it SHALL be a power of two and at least 2.
- REQ-003 The block SHALL have parameter FRAME_WORDS, default 64, giving the number of words per frame.
- REQ-004 The block SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame header byte.
- REQ-005 clk  input  1  single system clock; all logic is clocked on the rising edge.
- REQ-006 rst  input  1  reset, synchronous and active-high.
- REQ-007 in_data  input  8*WORD_BYTES  word to transmit, for example an FFT result.
- REQ-008 in_valid  input  1  in_data is valid this cycle.
- REQ-009 in_ready  output  1  the block can accept a word this cycle.
- REQ-010 tx_data  output  8  byte presented to the UART transmitter.
- REQ-011 tx_enable  output  1  start request to the UART transmitter.
- REQ-012 tx_busy  input  1  the UART transmitter is sending.
- REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.
- REQ-014 frame_done  output  1  one-cycle pulse when the last byte of a frame has completed.

Function
- REQ-015 A word SHALL be written into the FIFO on any rising edge where in_valid && in_ready.
- REQ-016 in_ready SHALL equal !full, where full means fifo_level == FIFO_DEPTH.
- REQ-017 The FSM SHALL have the states IDLE, HDR, LOAD, SEND, WAIT_ACK, WAIT_DONE.
- REQ-018 IDLE -> LOAD when the FIFO is non-empty and the word count is non-zero or FRAME_HDR_EN is undefined.
- REQ-019 IDLE -> HDR when the FIFO is non-empty, the word count is 0 and FRAME_HDR_EN is defined.
- REQ-020 LOAD SHALL pop one word into a shift register, set the byte index to 0, and go to SEND.
- REQ-021 SEND SHALL drive tx_data with the current byte and assert tx_enable, then go to WAIT_ACK; in HDR, tx_data SHALL equal SYNC_BYTE.
- REQ-022 WAIT_ACK SHALL hold tx_enable and tx_data stable until tx_busy == 1, then go to WAIT_DONE with tx_enable low.
- REQ-023 WAIT_DONE SHALL wait for tx_busy == 0, then go to the next byte, to LOAD or IDLE after the last byte of a word, or to LOAD after the header byte.
- REQ-024 Bytes SHALL be sent least-significant first: byte k = in_data[8k+7:8k].
- REQ-025 The word count SHALL increment after the last byte of each word and SHALL wrap to 0 after FRAME_WORDS words.
- REQ-026 frame_done SHALL pulse for exactly one cycle on that wrap.
- REQ-027 Latency: for a word accepted at edge N into an empty FIFO while in IDLE (with no header due), tx_enable SHALL be high after edge N+3.
- REQ-028 A simultaneous write and pop SHALL leave fifo_level unchanged.
- REQ-029 A write while the FIFO is full SHALL be impossible because in_ready == 0.
- REQ-030 A pop SHALL never occur while the FIFO is empty.
- REQ-031 If back-to-back words are available, LOAD SHALL follow WAIT_DONE directly with no IDLE cycle.
- REQ-032 A tx_busy level that is already high on entry to SEND SHALL still be treated as the acknowledge.

Reset
- REQ-033 On rst the block SHALL set state = IDLE, fifo_level = 0, word count = 0, byte index = 0, tx_enable = 0, tx_data = 8'h00 and frame_done = 0.
- REQ-034 While rst is asserted, in_ready SHALL be 0; on the cycle after release it SHALL be 1.
- REQ-035 A reset mid-byte SHALL abandon the word and its remaining bytes; tx_busy from the transmitter SHALL be ignored until IDLE is reached.

Configuration
- REQ-036 With macro UART_FRAME_HDR_EN defined, one SYNC_BYTE SHALL precede the first word of every frame.
- REQ-037 Without UART_FRAME_HDR_EN, no header SHALL be emitted; the HDR state and its logic SHALL be absent, and frame_done SHALL still pulse.

Structure
- REQ-038 Package uart_pkg SHALL hold the FSM state encoding, the default SYNC_BYTE and a BYTE_W = 8 constant.
- REQ-039 The FIFO SHALL be the sub-module sync_fifo, parameterised by width and depth, with registered full, empty and level.

Verification
- REQ-040 Single word: WORD_BYTES = 2 and in_data = 16'h1234 -> tx_data sequence 8'h34 then 8'h12, exactly two tx_enable handshakes.
- REQ-041 Header: UART_FRAME_HDR_EN defined and FRAME_WORDS = 2, words 16'hAAAA and 16'hBBBB -> bytes A5 AA AA BB BB, with frame_done pulsed once after the last byte.
- REQ-042 Backpressure: 9 words pushed back-to-back with tx_busy stuck high -> in_ready low at fifo_level 8, no word lost, and all 9 words sent in order once busy is released.
- REQ-043 Acknowledge: tx_busy rises 1 cycle after tx_enable -> tx_enable deasserts next cycle; tx_busy rises 5 cycles late -> tx_enable held for 5 cycles.
- REQ-044 Reset mid-word: rst pulsed during WAIT_DONE of byte 0 of 16'h5566 -> 8'h55 never sent, fifo_level = 0, in_ready high 1 cycle after release.
- REQ-045 Wrap: FRAME_WORDS = 3 and 7 words sent -> frame_done pulses after words 3 and 6 only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART word serializer.
// The HDR state exists only when UART_FRAME_HDR_EN is defined.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
`ifdef UART_FRAME_HDR_EN
    , ST_HDR     = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with registered full, empty and level flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             do_wr, do_rd;

  assign do_wr = wr_en_i && !full_q;
  assign do_rd = rd_en_i && !empty_q;

  always_comb begin
    level_d = level_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == DEPTH_L);
      empty_q <= (level_d == '0);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/uart_word_serializer.sv
// Buffers multi-byte words and hands them LSB-first to a byte UART with a enable/busy handshake.
// Define UART_FRAME_HDR_EN to prefix every frame of FRAME_WORDS words with SYNC_BYTE.
module uart_word_serializer
  import uart_pkg::*;
#(
  parameter int              WORD_BYTES  = 2,
  parameter int              FIFO_DEPTH  = 8,
  parameter int              FRAME_WORDS = 64,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [BYTE_W*WORD_BYTES-1:0]  in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [BYTE_W-1:0]             tx_data_o,
  output logic                          tx_enable_o,
  input  logic                          tx_busy_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_done_o
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(WORD_BYTES - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_en_q, tx_en_d;
  logic                fdone_q, fdone_d;
`ifdef UART_FRAME_HDR_EN
  logic                hdr_q, hdr_d;
`endif

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [WORD_W-1:0]   fifo_rd_data;

  assign in_ready_o = !fifo_full && !rst_i;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (in_valid_i && in_ready_o),
    .wr_data_i (in_data_i),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level_o)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bidx_d    = bidx_q;
    wcnt_d    = wcnt_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    fdone_d   = 1'b0;
    fifo_pop  = 1'b0;
`ifdef UART_FRAME_HDR_EN
    hdr_d     = hdr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
`ifdef UART_FRAME_HDR_EN
          state_d = (wcnt_q == '0) ? ST_HDR : ST_LOAD;
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef UART_FRAME_HDR_EN
      ST_HDR: begin
        tx_data_d = SYNC_BYTE;
        tx_en_d   = 1'b1;
        hdr_d     = 1'b1;
        state_d   = ST_WAIT_ACK;
      end
`endif
      ST_LOAD: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rd_data;
          bidx_d   = '0;
          state_d  = ST_SEND;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SEND: begin
        tx_data_d = shreg_q[BYTE_W-1:0];
        tx_en_d   = 1'b1;
        state_d   = ST_WAIT_ACK;
      end
      // busy is a level: already high on arrival still counts as the acknowledge
      ST_WAIT_ACK: begin
        if (tx_busy_i) begin
          tx_en_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
`ifdef UART_FRAME_HDR_EN
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = ST_LOAD;
          end else
`endif
          if (bidx_q != LAST_BYTE) begin
            bidx_d  = bidx_q + 1'b1;
            shreg_d = shreg_q >> BYTE_W;
            state_d = ST_SEND;
          end else begin
            bidx_d = '0;
            if (wcnt_q == LAST_WORD) begin
              wcnt_d  = '0;
              fdone_d = 1'b1;
            end else begin
              wcnt_d  = wcnt_q + 1'b1;
            end
            if (fifo_empty) begin
              state_d = ST_IDLE;
            end
`ifdef UART_FRAME_HDR_EN
            else if (wcnt_q == LAST_WORD) begin
              state_d = ST_HDR;
            end
`endif
            else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bidx_q    <= '0;
      wcnt_q    <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      fdone_q   <= 1'b0;
`ifdef UART_FRAME_HDR_EN
      hdr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bidx_q    <= bidx_d;
      wcnt_q    <= wcnt_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      fdone_q   <= fdone_d;
`ifdef UART_FRAME_HDR_EN
      hdr_q     <= hdr_d;
`endif
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_enable_o  = tx_en_q;
  assign frame_done_o = fdone_q;

endmodule

// File: tb/tb_uart_word_serializer.sv
// Bench for uart_word_serializer: a behavioural UART transmitter plus an expected-byte scoreboard.
module tb_uart_word_serializer;

  localparam int WB  = 2;
  localparam int FD  = 8;
  localparam int FW  = 3;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_FRAME_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BPF = FW * WB + HDR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_busy;
  logic        busy_m = 1'b0;
  logic        busy_f = 1'b0;
  logic [3:0]  fifo_level;
  logic        frame_done;

  assign tx_busy = busy_m | busy_f;

  uart_word_serializer #(
    .WORD_BYTES  (WB),
    .FIFO_DEPTH  (FD),
    .FRAME_WORDS (FW),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .tx_data_o    (tx_data),
    .tx_enable_o  (tx_enable),
    .tx_busy_i    (tx_busy),
    .fifo_level_o (fifo_level),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int words_acc = 0;
  int rx_total = 0;
  int rx_base = 0;
  int n_fd = 0;
  int fd_base = 0;
  logic [7:0] rx_last = '0;
  logic [7:0] rx_prev = '0;

  int phase = 0;
  int ack_dly = 0;
  int busy_len = 2;
  bit rnd_mode = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Behavioural transmitter: takes a byte when tx_enable is seen, raises busy
  // after a chosen delay, then stays busy for a while.
  initial begin
    int hi, wt, bl, cur_dly;
    logic [7:0] seen;
    logic [7:0] e;
    hi = 0; wt = 0; bl = 0; cur_dly = 0; seen = '0;
    forever begin
      @(negedge clk);
      case (phase)
        0: if (tx_enable) begin
          rx_total++;
          rx_prev = rx_last;
          rx_last = tx_data;
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_byte", tx_data, 0);
          end else begin
            e = exp_q.pop_front();
            check(tx_data == e, "byte", tx_data, e);
          end
          cur_dly = rnd_mode ? int'($urandom_range(0, 3)) : ack_dly;
          bl      = rnd_mode ? int'($urandom_range(1, 4)) : busy_len;
          hi = 1;
          seen = tx_data;
          if (cur_dly == 0) begin
            busy_m = 1'b1;
            phase = 2;
          end else begin
            wt = cur_dly;
            phase = 1;
          end
        end
        1: begin
          if (tx_enable && tx_data == seen) hi++;
          wt--;
          if (wt == 0) begin
            busy_m = 1'b1;
            phase = 2;
          end
        end
        2: begin
          check(hi == cur_dly + 1 && !tx_enable, "ack_handshake", hi, cur_dly + 1);
          phase = 3;
        end
        default: begin
          if (bl <= 1) begin
            busy_m = 1'b0;
            phase = 0;
          end else begin
            bl--;
          end
        end
      endcase
    end
  end

  initial begin
    bit fd_prev;
    fd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        n_fd++;
        check(!fd_prev, "fd_width", fd_prev, 0);
        check((rx_total - rx_base) == (n_fd - fd_base) * BPF, "fd_pos",
              rx_total - rx_base, (n_fd - fd_base) * BPF);
      end
      fd_prev = frame_done;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "bench timeout");
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [15:0] w);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      check(1'b0, "push_timeout", g, 2000);
    end else begin
      if (HDR == 1 && (words_acc % FW) == 0) exp_q.push_back(SYNC);
      for (int k = 0; k < WB; k++) exp_q.push_back(8'((w >> (8 * k)) & 16'h00FF));
      words_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (!(exp_q.size() == 0 && phase == 0 && !tx_busy && !tx_enable && fifo_level == 0)
           && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check(g < 5000, {"drain_", tag}, g, 5000);
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
    check(tx_enable == 1'b0, "rst_tx_enable", tx_enable, 0);
    check(tx_data == 8'h00, "rst_tx_data", tx_data, 0);
    check(fifo_level == 4'd0, "rst_fifo_level", fifo_level, 0);
    check(frame_done == 1'b0, "rst_frame_done", frame_done, 0);
    exp_q.delete();
    words_acc = 0;
    rx_base = rx_total;
    fd_base = n_fd;
    rst = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "rel_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          dly;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int start, exp_n, cnt, g, tgt, rx_snap;

    tbl[0] = '{word: 16'h1234, b0: 8'h34, b1: 8'h12, dly: 1};
    tbl[1] = '{word: 16'hABCD, b0: 8'hCD, b1: 8'hAB, dly: 5};
    tbl[2] = '{word: 16'h00FF, b0: 8'hFF, b1: 8'h00, dly: 0};
    tbl[3] = '{word: 16'h8001, b0: 8'h01, b1: 8'h80, dly: 2};

    @(negedge clk);
    reset_dut();

    for (int i = 0; i < 4; i++) begin
      ack_dly  = tbl[i].dly;
      busy_len = 2;
      start = rx_total;
      exp_n = WB + ((HDR == 1 && (words_acc % FW) == 0) ? 1 : 0);
      push_word(tbl[i].word);
      drain("table");
      check(rx_prev == tbl[i].b0, "table_byte0", rx_prev, tbl[i].b0);
      check(rx_last == tbl[i].b1, "table_byte1", rx_last, tbl[i].b1);
      check(rx_total - start == exp_n, "table_handshakes", rx_total - start, exp_n);
    end

    // Word into an empty FIFO mid-frame: enable must appear three edges after acceptance.
    ack_dly = 1;
    push_word(16'hC3E1);
    cnt = 0;
    while (!tx_enable && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check(cnt == 3, "latency", cnt, 3);
    drain("latency");

    // Busy already high when the first byte is offered.
    busy_f  = 1'b1;
    ack_dly = 0;
    start = rx_total;
    push_word(16'h7E81);
    g = 0;
    while (rx_total == start && g < 100) begin
      @(negedge clk);
      g++;
    end
    check(g < 100, "busy_on_entry_ack", g, 100);
    repeat (6) @(negedge clk);
    busy_f = 1'b0;
    drain("busy_on_entry");

    // Backpressure: transmitter stuck busy while nine words arrive.
    reset_dut();
    busy_f  = 1'b1;
    ack_dly = 0;
    fork
      begin
        for (int i = 0; i < 9; i++) push_word(16'h1000 + 16'(i * 16'h0111));
      end
    join_none
    g = 0;
    while (fifo_level != 4'd8 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(g < 200, "bp_reach_full", g, 200);
    check(in_ready == 1'b0, "bp_in_ready_full", in_ready, 0);
    repeat (5) @(negedge clk);
    check(fifo_level == 4'd8, "bp_level_hold", fifo_level, 8);
    check(in_ready == 1'b0, "bp_in_ready_hold", in_ready, 0);
    busy_f = 1'b0;
    wait fork;
    drain("backpressure");

    // Reset while the first data byte of 16'h5566 is in flight.
    ack_dly  = 1;
    busy_len = 6;
    tgt = rx_total + 1 + ((HDR == 1 && (words_acc % FW) == 0) ? 1 : 0);
    push_word(16'h5566);
    g = 0;
    while (!(rx_total == tgt && phase == 3) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(g < 200, "midword_reach", g, 200);
    check(rx_last == 8'h66, "midword_byte0", rx_last, 8'h66);
    rx_snap = rx_total;
    reset_dut();
    check(fifo_level == 4'd0, "midword_level", fifo_level, 0);
    repeat (40) @(negedge clk);
    check(rx_total == rx_snap, "midword_abandon", rx_total, rx_snap);
    check(phase == 0 && !tx_busy, "midword_quiet", phase, 0);

    // Frame wrap over seven words, then randomized traffic.
    rnd_mode = 1'b1;
    for (int i = 0; i < 7; i++) push_word(16'($urandom));
    drain("wrap");
    check(n_fd - fd_base == 2, "wrap_frame_done", n_fd - fd_base, 2);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_word(16'($urandom));
    end
    drain("random");
    check(n_fd - fd_base == words_acc / FW, "random_frame_done", n_fd - fd_base, words_acc / FW);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
